// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants, derived totals and the
//               coordinate type shared by the VGA timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int C_H_VISIBLE = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;
    localparam int C_V_VISIBLE = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;

    localparam int C_H_TOTAL = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;
    localparam int C_V_TOTAL = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;

    typedef logic [9:0] coord_t;

    // Half-open window test lo <= v < hi
    function automatic logic in_window(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One timing axis: wrapping counter plus sync/visible decode of
//               the counter's next value, so registered outputs line up.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = C_H_VISIBLE,
    parameter int FRONT   = C_H_FRONT,
    parameter int SYNC    = C_H_SYNC,
    parameter int BACK    = C_H_BACK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   at_last,
    output logic   sync_n_next,
    output logic   visible_next
);

    localparam int     C_TOTAL   = VISIBLE + FRONT + SYNC + BACK;
    localparam coord_t C_LAST    = coord_t'(C_TOTAL - 1);
    localparam int     C_SYNC_LO = VISIBLE + FRONT;
    localparam int     C_SYNC_HI = VISIBLE + FRONT + SYNC;

    coord_t r_count;
    coord_t w_next;

    assign at_last = (r_count == C_LAST);

    always_comb begin
        w_next = r_count;
        if (en) begin
            w_next = at_last ? '0 : r_count + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count        = r_count;
    assign sync_n_next  = ~in_window(w_next, C_SYNC_LO, C_SYNC_HI);
    assign visible_next = in_window(w_next, 0, VISIBLE);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator with pixel-clock enable. Optional
//               16-bit frame counter when VGA_TIMING_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = C_H_VISIBLE,
    parameter int H_FRONT   = C_H_FRONT,
    parameter int H_SYNC    = C_H_SYNC,
    parameter int H_BACK    = C_H_BACK,
    parameter int V_VISIBLE = C_V_VISIBLE,
    parameter int V_FRONT   = C_V_FRONT,
    parameter int V_SYNC    = C_V_SYNC,
    parameter int V_BACK    = C_V_BACK
) (
    input  logic   vga_clk,
    input  logic   reset,
    input  logic   pix_ce,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   hs,
    output logic   vs,
    output logic   blank,
    output logic   frame_start,
    output logic   line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    logic w_h_last, w_v_last;
    logic w_h_sync_n, w_v_sync_n;
    logic w_h_vis, w_v_vis;
    logic w_line_wrap, w_frame_wrap;

    logic r_hs, r_vs, r_blank, r_frame_start, r_line_start;

    assign w_line_wrap  = pix_ce & w_h_last;
    assign w_frame_wrap = w_line_wrap & w_v_last;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk          (vga_clk),
        .rst          (reset),
        .en           (pix_ce),
        .count        (DrawX),
        .at_last      (w_h_last),
        .sync_n_next  (w_h_sync_n),
        .visible_next (w_h_vis)
    );

    // Vertical axis steps once per completed line
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk          (vga_clk),
        .rst          (reset),
        .en           (w_line_wrap),
        .count        (DrawY),
        .at_last      (w_v_last),
        .sync_n_next  (w_v_sync_n),
        .visible_next (w_v_vis)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_hs          <= w_h_sync_n;
            r_vs          <= w_v_sync_n;
            r_blank       <= w_h_vis & w_v_vis;
            r_frame_start <= w_frame_wrap;
            r_line_start  <= w_line_wrap;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench: default horizontal timing, shortened
//               vertical timing, checked every cycle against a raster model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 6,   VF = 2,  VS = 2,  VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic [9:0] DrawX, DrawY;
    logic       hs, vs, blank, frame_start, line_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_gen #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .frame_start (frame_start),
        .line_start  (line_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Raster position model: where the beam is and what just wrapped
    int m_x = 0, m_y = 0;
    bit m_ls = 1'b0, m_fs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {7'd0, DrawX, DrawY, hs, vs, blank, frame_start, line_start};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic ehs, evs, eblank;
        ehs    = !(m_x >= HV + HF && m_x < HV + HF + HS);
        evs    = !(m_y >= VV + VF && m_y < VV + VF + VS);
        eblank = (m_x < HV) && (m_y < VV);
        return {7'd0, 10'(m_x), 10'(m_y), ehs, evs, eblank, m_fs, m_ls};
    endfunction

    task automatic step(input bit r, input bit ce);
        reset  = r;
        pix_ce = ce;
        @(posedge vga_clk);
        if (r) begin
            m_x = 0; m_y = 0; m_ls = 1'b0; m_fs = 1'b0;
        end else if (ce) begin
            m_ls = (m_x == HT - 1);
            m_fs = m_ls && (m_y == VT - 1);
            m_x  = (m_x + 1) % HT;
            if (m_ls) m_y = (m_y + 1) % VT;
        end else begin
            m_ls = 1'b0; m_fs = 1'b0;
        end
        #1;
        check("cycle", obs_vec(), exp_vec());
    endtask

    initial begin
        int last_fs, fs_cnt, ls_prev, ls_bad, ls_in_frame, blank_cnt;
        int hs_run, hs_fall_x, hs_rise_x, hs_run_first, vs_run, vs_max;
        int hold, hold_bad, fs_w, fs_bad, fs_n, z_run, z_bad, z_n;
        bit first, found;
        logic [9:0] px;

        reset = 1'b1;
        pix_ce = 1'b0;
        step(1, 1);
        step(1, 0);
        check("rst_x", DrawX, 0);
        check("rst_y", DrawY, 0);
        check("rst_syncs_blank", {hs, vs, blank}, 3'b111);
        check("rst_pulses", {frame_start, line_start}, 2'b00);

        // Free-running pixel clock for two frames
        last_fs = -1; fs_cnt = 0; ls_prev = -1; ls_bad = 0; ls_in_frame = 0;
        blank_cnt = 0; hs_run = 0; hs_fall_x = -1; hs_rise_x = -1;
        hs_run_first = -1; vs_run = 0; vs_max = 0;
        for (int i = 1; i <= 2 * FRAME + 2; i++) begin
            step(0, 1);
            if (i <= FRAME && blank) blank_cnt++;
            if (line_start) begin
                if (ls_prev >= 0 && i - ls_prev != HT) ls_bad++;
                ls_prev = i;
                if (i <= FRAME) ls_in_frame++;
            end
            if (frame_start) begin
                fs_cnt++;
                if (last_fs < 0) check("first_fs_cycle", i, FRAME);
                else             check("fs_interval", i - last_fs, FRAME);
                last_fs = i;
            end
            if (!hs) begin
                if (hs_run == 0 && hs_fall_x < 0) hs_fall_x = int'(DrawX);
                hs_run++;
            end else if (hs_run > 0) begin
                if (hs_rise_x < 0) begin
                    hs_rise_x    = int'(DrawX);
                    hs_run_first = hs_run;
                end
                hs_run = 0;
            end
            if (!vs) vs_run++; else vs_run = 0;
            if (vs_run > vs_max) vs_max = vs_run;
        end
        check("fs_count", fs_cnt, 2);
        check("ls_interval_bad", ls_bad, 0);
        check("ls_per_frame", ls_in_frame, VT);
        check("blank_per_frame", blank_cnt, HV * VV);
        check("hs_fall_x", hs_fall_x, HV + HF);
        check("hs_rise_x", hs_rise_x, HV + HF + HS);
        check("hs_low_len", hs_run_first, HS);
        check("vs_low_len", vs_max, VS * HT);

        // Enable toggling 1,0,1,0 across a frame boundary
        hold = 0; hold_bad = 0; first = 1'b1; px = DrawX;
        fs_w = 0; fs_bad = 0; fs_n = 0; z_run = 0; z_bad = 0; z_n = 0;
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            step(0, (i % 2) == 0);
            if (DrawX == px) hold++;
            else begin
                if (!first && hold != 2) hold_bad++;
                first = 1'b0; hold = 1; px = DrawX;
            end
            if (frame_start) fs_w++;
            else if (fs_w > 0) begin
                fs_n++;
                if (fs_w != 1) fs_bad++;
                fs_w = 0;
            end
            if (DrawX == 0 && DrawY == 0) z_run++;
            else if (z_run > 0) begin
                z_n++;
                if (z_run != 2) z_bad++;
                z_run = 0;
            end
        end
        check("ce_hold_bad", hold_bad, 0);
        check("ce_fs_count", fs_n, 1);
        check("ce_fs_width_bad", fs_bad, 0);
        check("ce_origin_count", z_n, 1);
        check("ce_origin_hold_bad", z_bad, 0);

        // Random enable with occasional reset
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 700) == 0, ($urandom % 4) != 0);
        end

        // Reset in the middle of a frame
        step(1, 0);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step(0, 1);
            if (m_x == 300 && m_y == 4) found = 1'b1;
        end
        check("reach_300_4", found, 1'b1);
        step(1, 1);
        check("midrst_state", obs_vec(), {7'd0, 10'd0, 10'd0, 5'b11100});
        step(0, 0);
        check("midrst_hold_x", DrawX, 0);
        step(0, 1);
        check("midrst_resume_x", DrawX, 1);

        // Reset wins over a simultaneous frame wrap
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step(0, 1);
            if (m_x == HT - 1 && m_y == VT - 1) found = 1'b1;
        end
        check("reach_last", found, 1'b1);
        step(1, 1);
        check("wrap_rst_state", obs_vec(), {7'd0, 10'd0, 10'd0, 5'b11100});

`ifdef VGA_TIMING_FRAME_CNT_EN
        check("fcnt_after_rst", frame_cnt, 0);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        check("fcnt_preload", frame_cnt, 16'hFFFF);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step(0, 1);
            if (frame_start) found = 1'b1;
        end
        check("fcnt_fs_seen", found, 1'b1);
        check("fcnt_wrap", frame_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, in pixels.
REQ-004 SHALL have parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync width, in lines.
REQ-008 SHALL have parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 SHALL use one clock; reset is synchronous and active-high.
REQ-010 SHALL have port vga_clk, input, 1 bit: sole clock.
REQ-011 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-012 SHALL have port pix_ce, input, 1 bit: pixel-clock enable; counters advance only when it is 1.
REQ-013 SHALL have port DrawX, output, 10 bits: current horizontal count.
REQ-014 SHALL have port DrawY, output, 10 bits: current vertical count.
REQ-015 SHALL have port hs, output, 1 bit: horizontal sync, active-low.
REQ-016 SHALL have port vs, output, 1 bit: vertical sync, active-low.
REQ-017 SHALL have port blank, output, 1 bit: 1 = visible region (display enable), 0 = blanked.
REQ-018 SHALL have port frame_start, output, 1 bit: one-cycle pulse when the counters wrap to (0,0).
REQ-019 SHALL have port line_start, output, 1 bit: one-cycle pulse when DrawX wraps to 0.

Function
REQ-020 SHALL define H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (default 800) and V_TOTAL likewise (default 525).
REQ-021 SHALL make DrawX a register: on a pix_ce cycle it increments, and wraps H_TOTAL-1 -> 0; it holds when pix_ce = 0.
REQ-022 SHALL increment DrawY only on pix_ce cycles where DrawX wraps, and wrap DrawY V_TOTAL-1 -> 0.
REQ-023 SHALL register hs, vs and blank, and compute them from the next-state counters, so they are cycle-aligned with DrawX/DrawY (zero relative latency).
REQ-024 SHALL drive hs = 0 exactly while H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
REQ-025 SHALL drive vs = 0 exactly while V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), for the whole of each such line.
REQ-026 SHALL drive blank = 1 exactly while DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-027 SHALL assert line_start for exactly the one vga_clk cycle in which DrawX first equals 0 after a wrap.
REQ-028 SHALL assert frame_start for exactly the one vga_clk cycle in which (DrawX, DrawY) first equals (0,0) after a wrap; frame_start implies line_start.
REQ-029 SHALL deassert both pulses on the next vga_clk edge even if pix_ce = 0 holds the counters at (0,0).
REQ-030 SHALL keep pix_ce held at 1 equivalent to a free-running pixel clock at vga_clk rate.

Reset
REQ-031 SHALL, on reset, set DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 1, frame_start = 0, line_start = 0 at the next vga_clk edge, regardless of pix_ce.
REQ-032 SHALL let reset asserted mid-frame abort the frame with no frame_start or line_start pulse; counting resumes from (0,0) on the first pix_ce cycle after release, yielding (1,0).
REQ-033 SHALL give reset priority over pix_ce and over counter wrap in the same cycle.

Configuration
REQ-034 SHALL, with macro VGA_TIMING_FRAME_CNT_EN defined, add output port frame_cnt, 16 bits, reset to 0, incremented in the cycle frame_start asserts, wrapping 65535 -> 0.
REQ-035 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit the frame_cnt port and its register entirely; all other behaviour is identical.

Structure
REQ-036 SHALL place the default timing constants (640/16/96/48, 480/10/2/33), the H_TOTAL/V_TOTAL derivations and typedef coord_t (logic [9:0]) in package vga_timing_pkg.
REQ-037 SHALL implement the counting with one sub-module, vga_axis_counter (count, wrap, sync-window and visible-window decode), instantiated twice: horizontal, and vertical enabled by the horizontal wrap.

Verification
REQ-038 SHALL check: pix_ce = 1 for 2 frames after reset -> frame_start pulses exactly 420000 cycles apart, line_start every 800 cycles, 525 line_starts per frame.
REQ-039 SHALL check: DrawX 655 -> 656 -> hs falls on the same edge; at 752 hs returns to 1; hs low is 96 cycles per line.
REQ-040 SHALL check: lines 490 and 491 -> vs = 0 for 1600 consecutive pix_ce cycles; blank = 1 count per frame is 307200.
REQ-041 SHALL check: pix_ce toggling 1,0,1,0 -> each DrawX value held 2 cycles; frame_start pulse is 1 cycle wide while (0,0) is held 2 cycles.
REQ-042 SHALL check: reset at DrawX = 300, DrawY = 200 -> next edge DrawX = 0, DrawY = 0, hs = vs = blank = 1, no pulses; after release + 1 pix_ce, DrawX = 1.
REQ-043 SHALL check, with VGA_TIMING_FRAME_CNT_EN: preload frame_cnt = 65535 via force -> the next frame_start wraps it to 0.
